// File: rtl/pa_spsram_512x4_ctrl.sv
// Access controller for a single-port SRAM macro: arbitrates refill writes against lookup
// reads, and runs an INIT_DATA sweep over the whole array after reset and on invalidate-all.
module pa_spsram_512x4_ctrl #(
  parameter int                    ADDR_WIDTH    = 9,
  parameter int                    DATA_WIDTH    = 4,
  parameter int                    INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA     = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  inv_req,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  inv_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? SWEEP : IDLE;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      rd_vld  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_vld  <= rd_gnt;
    end
  end

  // Handshake: a request is accepted exactly in a cycle where its grant is high; the
  // requester holds req (and its address/data) until then. Nothing is queued in here.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_gnt   = 1'b0;
    rd_gnt   = 1'b0;
    inv_done = 1'b0;
    A        = '0;
    CEN      = 1'b1;
    GWEN     = 1'b1;
    WEN      = '1;
    D        = '0;
    case (state_q)
      SWEEP: begin
        CEN   = 1'b0;
        GWEN  = 1'b0;
        WEN   = '0;
        A     = cnt_q;
        D     = INIT_DATA;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          inv_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        if (inv_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (wr_req) begin
          wr_gnt = 1'b1;
          CEN    = 1'b0;
          GWEN   = 1'b0;
          WEN    = ~wr_mask;
          A      = wr_addr;
          D      = wr_data;
        end else if (rd_req) begin
          rd_gnt = 1'b1;
          CEN    = 1'b0;
          A      = rd_addr;
        end
      end
    endcase
  end

  assign busy    = (state_q == SWEEP);
  assign rd_data = Q;

endmodule

// File: tb/tb_pa_spsram_512x4_ctrl.sv
// Bench for pa_spsram_512x4_ctrl: behavioural SRAM macro, table of idle decode vectors,
// hand sequences for sweep/reset/arbitration corners, and a randomized model-checked run.
module tb_pa_spsram_512x4_ctrl;

  logic       clk;
  logic       rst;
  logic       inv_req, wr_req, rd_req;
  logic [8:0] wr_addr, rd_addr;
  logic [3:0] wr_data, wr_mask;
  logic       wr_gnt, rd_gnt, rd_vld, busy, inv_done;
  logic [3:0] rd_data;
  logic [8:0] A;
  logic       CEN, GWEN;
  logic [3:0] WEN, D, Q;

  int checks   = 0;
  int failures = 0;

  pa_spsram_512x4_ctrl dut (
    .CLK(clk), .RST(rst), .inv_req(inv_req),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .busy(busy), .inv_done(inv_done),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural single-port macro: write at the edge, read data appears after the edge
  logic [3:0] sram [512];
  initial Q = 4'h0;
  always @(posedge clk) begin
    if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       Q <= sram[A];
    end
  end

  function automatic logic [23:0] act_vec();
    return {busy, inv_done, wr_gnt, rd_gnt, rd_vld, CEN, GWEN, WEN, A, D};
  endfunction

  function automatic logic [23:0] exp_vec(input logic e_busy, e_done, e_wg, e_rg, e_vld,
                                          input logic e_cen, e_gwen, input logic [3:0] e_wen,
                                          input logic [8:0] e_a, input logic [3:0] e_d);
    return {e_busy, e_done, e_wg, e_rg, e_vld, e_cen, e_gwen, e_wen, e_a, e_d};
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    inv_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr = '0;
  endtask

  // caller is already inside cycle 0 (just after a negedge) when this starts
  task automatic sweep_task(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("sweep_k%0d", k), act_vec(),
          exp_vec(1'b1, k == 511, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 9'(k), 4'h0));
    end
  endtask

  typedef struct {
    logic       inv, wr, rd;
    logic [8:0] wa;
    logic [3:0] wd, wm;
    logic [8:0] ra;
    logic       wg, rg, cen, gwen;
    logic [3:0] wen;
    logic [8:0] a;
    logic [3:0] d;
  } vec_t;

  vec_t vecs[7];

  // reference model state for the random run
  logic [3:0] ref_mem [512];
  logic [3:0] exp_q[$];
  int         sweep_left = 0;
  logic       m_vld = 1'b0;

  task automatic rnd_step(input logic inv, wr, rd, input logic [8:0] wa, ra,
                          input logic [3:0] wd, wm);
    logic [23:0] e;
    logic [3:0]  ed;
    logic        nxt_vld;
    @(negedge clk);
    inv_req = inv; wr_req = wr; rd_req = rd;
    wr_addr = wa; rd_addr = ra; wr_data = wd; wr_mask = wm;
    nxt_vld = 1'b0;
    if (sweep_left > 0) begin
      e = exp_vec(1'b1, sweep_left == 1, 1'b0, 1'b0, m_vld, 1'b0, 1'b0, 4'h0,
                  9'(512 - sweep_left), 4'h0);
      ref_mem[512 - sweep_left] = 4'h0;
      sweep_left--;
    end else if (inv) begin
      e = exp_vec(1'b0, 1'b0, 1'b0, 1'b0, m_vld, 1'b1, 1'b1, 4'hF, 9'h0, 4'h0);
      sweep_left = 512;
    end else if (wr) begin
      e = exp_vec(1'b0, 1'b0, 1'b1, 1'b0, m_vld, 1'b0, 1'b0, ~wm, wa, wd);
      ref_mem[wa] = (ref_mem[wa] & ~wm) | (wd & wm);
    end else if (rd) begin
      e = exp_vec(1'b0, 1'b0, 1'b0, 1'b1, m_vld, 1'b0, 1'b1, 4'hF, ra, 4'h0);
      exp_q.push_back(ref_mem[ra]);
      nxt_vld = 1'b1;
    end else begin
      e = exp_vec(1'b0, 1'b0, 1'b0, 1'b0, m_vld, 1'b1, 1'b1, 4'hF, 9'h0, 4'h0);
    end
    #1;
    chk("rnd_pins", act_vec(), e);
    if (m_vld) begin
      ed = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hX;
      chk("rnd_rd_data", {20'h0, rd_data}, {20'h0, ed});
    end
    m_vld = nxt_vld;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 9'h000, 4'h0, 4'h0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 9'h000, 4'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 9'h055, 4'hA, 4'hF, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 9'h055, 4'hA};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 9'h0F0, 4'h5, 4'h0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 9'h0F0, 4'h5};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 9'h000, 4'h0, 4'h0, 9'h1FF, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 9'h1FF, 4'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 9'h012, 4'h3, 4'hC, 9'h034, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 9'h012, 4'h3};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 9'h012, 4'h3, 4'hF, 9'h034, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 9'h000, 4'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 9'h100, 4'h4, 4'h6, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 9'h100, 4'h4};
    for (int i = 0; i < 512; i++) ref_mem[i] = 4'h0;

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", act_vec(), exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 9'h0, 4'h0));

    // sweep after reset release
    @(negedge clk);
    rst = 1'b0;
    sweep_task(512);
    @(negedge clk); #1;
    chk("post_sweep_idle", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 9'h0, 4'h0));

    // idle decode table; requests are withdrawn before the edge so state is untouched
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      inv_req = vecs[i].inv; wr_req = vecs[i].wr; rd_req = vecs[i].rd;
      wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_mask = vecs[i].wm; rd_addr = vecs[i].ra;
      #1;
      chk($sformatf("table_%0d", i), act_vec(),
          exp_vec(1'b0, 1'b0, vecs[i].wg, vecs[i].rg, 1'b0, vecs[i].cen, vecs[i].gwen,
                  vecs[i].wen, vecs[i].a, vecs[i].d));
      #1;
      clear_inputs();
    end

    // full write then read-back
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 9'h1A5; wr_data = 4'b1011; wr_mask = 4'b1111;
    #1; chk("wr_full", act_vec(), exp_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 9'h1A5, 4'hB));
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 9'h1A5;
    #1; chk("rd_after_wr", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 9'h1A5, 4'h0));
    @(negedge clk);
    rd_req = 1'b0;
    #1; chk("rd_vld_1", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h0, 4'h0));
    chk("rd_data_1", {20'h0, rd_data}, {20'h0, 4'b1011});

    // masked write over stored 1011
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 9'h1A5; wr_data = 4'b0100; wr_mask = 4'b0110;
    #1; chk("wr_masked", act_vec(), exp_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 9'h1A5, 4'h4));
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 9'h1A5;
    @(negedge clk);
    rd_req = 1'b0;
    #1; chk("rd_data_masked", {20'h0, rd_data}, {20'h0, 4'b1101});

    // write and read contend: write wins for three cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wr_req = 1'b1; wr_addr = 9'h0A3; wr_data = 4'h7; wr_mask = 4'hF;
      rd_req = 1'b1; rd_addr = 9'h1A5;
      #1; chk($sformatf("contend_%0d", c), act_vec(),
              exp_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 9'h0A3, 4'h7));
    end
    @(negedge clk);
    wr_req = 1'b0;
    #1; chk("contend_rd_gnt", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 9'h1A5, 4'h0));
    @(negedge clk);
    rd_req = 1'b0;
    #1; chk("contend_rd_vld", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h0, 4'h0));
    chk("contend_rd_data", {20'h0, rd_data}, {20'h0, 4'b1101});

    // invalidate with a read held across the sweep
    @(negedge clk);
    inv_req = 1'b1; rd_req = 1'b1; rd_addr = 9'h1A5;
    #1; chk("inv_no_gnt", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 9'h0, 4'h0));
    @(negedge clk);
    inv_req = 1'b0;
    sweep_task(512);
    @(negedge clk); #1;
    chk("inv_rd_gnt", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 9'h1A5, 4'h0));
    @(negedge clk);
    rd_req = 1'b0;
    #1; chk("inv_rd_vld", {23'h0, rd_vld}, 24'h1);
    chk("inv_rd_data", {20'h0, rd_data}, {20'h0, 4'b0000});

    // reset pulsed mid-sweep
    @(negedge clk);
    inv_req = 1'b1;
    #1; chk("inv2_no_gnt", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 9'h0, 4'h0));
    @(negedge clk);
    inv_req = 1'b0;
    sweep_task(200);
    @(negedge clk);
    rst = 1'b1;
    #1; chk("mid_reset", act_vec(), exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 9'h0, 4'h0));
    @(negedge clk);
    rst = 1'b0;
    sweep_task(512);
    @(negedge clk); #1;
    chk("mid_reset_idle", act_vec(), exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 9'h0, 4'h0));

    // randomized traffic against the reference model
    for (int n = 0; n < 700; n++) begin
      rnd_step($urandom_range(0, 249) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    for (int n = 0; n < 600 && (sweep_left > 0 || m_vld); n++) begin
      rnd_step(1'b0, 1'b0, 1'b0, 9'h0, 9'h0, 4'h0, 4'h0);
    end
    chk("rnd_drained", {23'h0, m_vld}, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pa_spsram_512x4_ctrl.md
Name: pa_spsram_512x4_ctrl

Overview:
- Access controller for one 512x4 single-port SRAM macro (tag/valid-style array in the IFU).
- Arbitrates between a refill-write requester and a lookup-read requester.
- Runs a hardware sweep that writes INIT_DATA to every entry, automatically after reset and on an invalidate-all request.
- Drives the macro pins (active-low CEN/GWEN/WEN) and returns read data with a one-cycle-latency valid strobe.

Parameters:
- ADDR_WIDTH, 9, SRAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 4, SRAM data width; equals per-bit write-enable width.
- INIT_ON_RESET, 1, 1 = start sweep on reset release; 0 = come up IDLE.
- INIT_DATA, 4'b0000, value written to every entry during a sweep.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- inv_req  in  1  pulse: invalidate whole array.
- wr_req  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_mask  in  DATA_WIDTH  per-bit write enable, 1 = write bit.
- wr_gnt  out  1  write accepted this cycle.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_gnt  out  1  read accepted this cycle.
- rd_vld  out  1  rd_data valid; one cycle after rd_gnt.
- rd_data  out  DATA_WIDTH  read data (macro Q passthrough).
- busy  out  1  sweep in progress.
- inv_done  out  1  one-cycle pulse on the last sweep write.
- A  out  ADDR_WIDTH  macro address.
- CEN  out  1  macro chip enable, active-low.
- GWEN  out  1  macro global write enable, active-low.
- WEN  out  DATA_WIDTH  macro per-bit write enable, active-low.
- D  out  DATA_WIDTH  macro write data.
- Q  in  DATA_WIDTH  macro read data.

Behaviour:
- States: IDLE, SWEEP. RST drives state to SWEEP if INIT_ON_RESET = 1, else IDLE.
- Reset values: sweep counter 0, rd_vld 0, inv_done 0. busy = (state == SWEEP).
- Macro pins are combinational from state and grants. Idle macro pins: CEN=1, GWEN=1, WEN all 1s, A=0, D=0.
- SWEEP, every cycle:
  - CEN=0, GWEN=0, WEN all 0s, A=cnt, D=INIT_DATA; cnt increments.
  - At cnt == 2^ADDR_WIDTH-1: inv_done=1, cnt wraps to 0, state -> IDLE next cycle. A sweep takes exactly 512 cycles.
  - wr_gnt=0, rd_gnt=0; requesters hold their requests.
  - inv_req is ignored (the sweep already covers the array).
- IDLE, priority inv_req > wr_req > rd_req:
  - inv_req=1: no grant this cycle, pins idle, state -> SWEEP, cnt=0.
  - Else wr_req=1: wr_gnt=1, CEN=0, GWEN=0, WEN=~wr_mask, A=wr_addr, D=wr_data.
  - Else rd_req=1: rd_gnt=1, CEN=0, GWEN=1, WEN all 1s, A=rd_addr.
  - Grants are combinational from requests and state. No request is held across cycles inside the block.
- Write with wr_mask = 0 is still granted and enables the macro, but writes no bits.
- rd_vld is a register that loads rd_gnt. rd_data = Q. Q is only meaningful while rd_vld=1.
- Simultaneous wr_req and rd_req: write wins; read stalls (rd_gnt=0) until a cycle with no write and no sweep.
- Read of an address in the cycle after its write returns the new data (macro write-then-read ordering). No bypass logic.
- RST asserted mid-sweep or mid-read: state and counter reset immediately, rd_vld clears, a pending read is lost. With INIT_ON_RESET=1 the sweep restarts from entry 0.

Test Plan:
- Reset release with INIT_ON_RESET=1 -> busy=1 for 512 cycles; A goes 0..511 with CEN=0, GWEN=0, WEN=0000, D=0000; inv_done pulses when A=511; busy=0 on the next cycle.
- IDLE, write addr 0x1A5 data 4'b1011 mask 4'b1111; next cycle read 0x1A5 -> wr_gnt=1, WEN=0000; then rd_gnt=1, GWEN=1; next cycle rd_vld=1, rd_data=4'b1011.
- Masked write 4'b0100 mask 4'b0110 over stored 4'b1011, then read -> rd_data=4'b1101; WEN during the write = 4'b1001.
- wr_req and rd_req held together for 3 cycles, then wr_req drops -> wr_gnt=1 for 3 cycles, rd_gnt=0; rd_gnt=1 on cycle 4; rd_vld on cycle 5.
- inv_req in IDLE with rd_req held -> no grant that cycle, then 512-cycle sweep with rd_gnt=0; rd_gnt rises the cycle after inv_done; reading a previously written address returns 4'b0000.
- RST pulsed at sweep count 200 -> busy stays 1 and the sweep restarts at A=0; inv_done appears only 512 cycles after RST deasserts.
